vga_sprite_multi_core: RTL and testbench
========================================

VGA_SPRITE_MULTI_CORE -- requirements
Module: vga_sprite_multi_core

Interface
REQ-001 SHALL have parameter CD, default 12: colour depth in bits.
REQ-002 SHALL have parameter N_SPR, default 4: sprite channel count, power of 2, range 1..8.
REQ-003 SHALL have parameter SW, default 32: sprite width and height in pixels, power of 2.
REQ-004 SHALL have parameter N_FRM, default 2: animation frames per sprite, power of 2.
REQ-005 SHALL have parameter KEY_COLOR, default 12'h000: transparent colour.
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have ports x and y, input, 11 each: frame-counter pixel position.
REQ-009 SHALL have port cs, input, 1: chip select.
REQ-010 SHALL have port write, input, 1: write strobe.
REQ-011 SHALL have port addr, input, 14: word address.
REQ-012 SHALL have port wr_data, input, 32: write data.
REQ-013 SHALL have port si_rgb, input, CD: upstream pixel.
REQ-014 SHALL have port so_rgb, output, CD: downstream pixel.

Function
REQ-015 SHALL qualify writes as cs&write; addr[13]=0 selects pixel RAM, addr[13]=1 selects registers.
REQ-016 SHALL store wr_data[CD-1:0] into RAM word {sprite, frame, row, col} = addr[12:0] (defaults: [12:11] sprite, [10] frame, [9:5] row, [4:0] col).
REQ-017 SHALL decode per-sprite registers at addr[13]=1, addr[12]=0, sprite index addr[5:3], register addr[2:0]: 0 ctrl (bit0 en, bit1 hflip, bit2 anim_en), 1 x0[10:0], 2 y0[10:0], 3 frame[log2 N_FRM-1:0], 4 period[5:0].
REQ-018 SHALL implement a global bypass bit at addr[13]=1, addr[12]=1 (wr_data[0]); bypass=1 forces so_rgb = delayed si_rgb.
REQ-019 SHALL ignore writes to unmapped register offsets or to sprite index >= N_SPR.
REQ-020 SHALL treat a sprite as hit when x0<=x<x0+SW and y0<=y<y0+SW, evaluated at 12-bit width so x0+SW beyond 2047 does not wrap.
REQ-021 SHALL use column (SW-1)-(x-x0) when hflip=1, else x-x0; row = y-y0.
REQ-022 SHALL read RAM synchronously and register so_rgb, giving a fixed latency of 2 clk from x/y/si_rgb to so_rgb; si_rgb SHALL be delayed to match.
REQ-023 SHALL select the lowest-index sprite that is enabled, hit, and non-KEY_COLOR; with none, so_rgb = delayed si_rgb.
REQ-024 SHALL generate frame_tick as a 1-clk pulse on the rising edge of (x==0 && y==0), exactly once per frame even when x/y hold for several clocks.
REQ-025 SHALL, per sprite with anim_en=1, count frame_ticks; when the count reaches period the frame advances (N_FRM-1 wraps to 0) and the count clears, so period P steps every P+1 frames.
REQ-026 SHALL make a CPU write of frame or period override a same-cycle frame_tick, clearing that sprite's count.
REQ-027 SHALL freeze the frame and hold the count at 0 while anim_en=0.
REQ-028 SHALL make RAM writes and video reads concurrent (true dual-port), with no read-during-write guarantee on the same word.

Reset
REQ-029 SHALL, on reset_n=0 at any time, immediately clear all registers (en, hflip, anim_en, x0, y0, frame, period, counts, bypass), the pipeline, and so_rgb to 0.
REQ-030 SHALL leave RAM contents uninitialised and unaffected by reset.

Structure
REQ-031 SHALL place the register offsets, the ctrl bit positions, and the sprite_regs_t struct (en, hflip, anim_en, x0, y0, frame, period, count) in package vga_sprite_pkg.
REQ-032 SHALL instantiate one sub-module sprite_chan per sprite via generate, containing its RAM slice, hit/address logic, and animation counter.

Verification
REQ-033 SHALL test: sprite 0 en, x0=100, y0=50, RAM(0,0,0,0)=12'hF00 -> so_rgb=F00 two clk after x=100, y=50; si_rgb at x=99.
REQ-034 SHALL test: sprites 0 and 1 overlapping, both opaque -> sprite 0 colour; sprite 0 pixel = KEY_COLOR -> sprite 1 colour.
REQ-035 SHALL test: hflip=1, col 31=12'h0F0, x0=0 -> 0F0 at x=0.
REQ-036 SHALL test: anim_en=1, period=2 -> frame toggles after every 3rd frame_tick; x,y held at 0 for 4 clk -> one tick.
REQ-037 SHALL test: x0=2040 -> hit for x in 2040..2047, no hit at x=0..23; bypass=1 -> so_rgb = si_rgb delayed 2.
REQ-038 SHALL test: reset_n low mid-frame -> so_rgb=0 and en=0 immediately; RAM data intact after release.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Shared definitions for the multi-sprite overlay.
// Register map offsets, ctrl bit positions and per-sprite state.
package vga_sprite_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_X0     = 3'd1;
  localparam logic [2:0] REG_Y0     = 3'd2;
  localparam logic [2:0] REG_FRAME  = 3'd3;
  localparam logic [2:0] REG_PERIOD = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_HFLIP = 1;
  localparam int CTRL_ANIM  = 2;

  // frame is sized for the largest supported frame count
  localparam int FRM_W = 3;
  localparam int PER_W = 6;

  typedef struct packed {
    logic             en;
    logic             hflip;
    logic             anim_en;
    logic [10:0]      x0;
    logic [10:0]      y0;
    logic [FRM_W-1:0] frame;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] count;
  } sprite_regs_t;

endpackage

// File: rtl/sprite_chan.sv
// One sprite channel: pixel RAM slice, register set,
// hit/address generation and animation frame counter.
module sprite_chan
  import vga_sprite_pkg::*;
#(
  parameter int CD    = 12,
  parameter int SW    = 32,
  parameter int N_FRM = 2,
  parameter int AW    = 2*$clog2(SW) + $clog2(N_FRM)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          frame_tick,
  input  logic          ram_we,
  input  logic [AW-1:0] ram_waddr,
  input  logic [CD-1:0] ram_wdata,
  input  logic          reg_we,
  input  logic [2:0]    reg_off,
  input  logic [10:0]   reg_wdata,
  output logic          hit_q,
  output logic [CD-1:0] pix_q
);

  localparam int SB    = $clog2(SW);
  localparam int DEPTH = 1 << AW;
  localparam logic [FRM_W-1:0] FMAX = FRM_W'(N_FRM-1);

  logic [CD-1:0] mem [DEPTH];

  sprite_regs_t regs_q, regs_d;
  logic         hit_d;
  logic [11:0]  x12, y12, x0e, y0e;
  logic [10:0]  dx, dy;
  logic [SB-1:0] col, row;
  logic [AW-1:0] rd_addr;

  // register writes, animation stepping; cpu write wins over a tick
  always_comb begin
    regs_d = regs_q;
    if (!regs_q.anim_en) begin
      regs_d.count = '0;
    end else if (frame_tick) begin
      if (regs_q.count == regs_q.period) begin
        regs_d.count = '0;
        if (regs_q.frame == FMAX) regs_d.frame = '0;
        else regs_d.frame = regs_q.frame + 1'b1;
      end else begin
        regs_d.count = regs_q.count + 1'b1;
      end
    end
    if (reg_we) begin
      case (reg_off)
        REG_CTRL: begin
          regs_d.en      = reg_wdata[CTRL_EN];
          regs_d.hflip   = reg_wdata[CTRL_HFLIP];
          regs_d.anim_en = reg_wdata[CTRL_ANIM];
        end
        REG_X0: regs_d.x0 = reg_wdata;
        REG_Y0: regs_d.y0 = reg_wdata;
        REG_FRAME: begin
          regs_d.frame = reg_wdata[FRM_W-1:0] & FMAX;
          regs_d.count = '0;
        end
        REG_PERIOD: begin
          regs_d.period = reg_wdata[PER_W-1:0];
          regs_d.count  = '0;
        end
        default: ;
      endcase
    end
  end

  // hit test at 12 bits so the right edge never wraps past 2047
  always_comb begin
    x12 = {1'b0, x};
    y12 = {1'b0, y};
    x0e = {1'b0, regs_q.x0};
    y0e = {1'b0, regs_q.y0};
    hit_d = regs_q.en
          && (x12 >= x0e) && (x12 < x0e + 12'(SW))
          && (y12 >= y0e) && (y12 < y0e + 12'(SW));
    dx  = x - regs_q.x0;
    dy  = y - regs_q.y0;
    col = regs_q.hflip ? ~dx[SB-1:0] : dx[SB-1:0];
    row = dy[SB-1:0];
    rd_addr = AW'({regs_q.frame, row, col});
  end

  // register state and hit flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      hit_q  <= hit_d;
    end
  end

  // dual-port pixel RAM, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    pix_q <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_sprite_multi_core.sv
// Multi-sprite overlay on a pixel stream, 2-clk latency.
// Bus decode, frame tick, priority mux and output register.
module vga_sprite_multi_core
  import vga_sprite_pkg::*;
#(
  parameter int            CD        = 12,
  parameter int            N_SPR     = 4,
  parameter int            SW        = 32,
  parameter int            N_FRM     = 2,
  parameter logic [CD-1:0] KEY_COLOR = CD'(12'h000)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int AW = 2*$clog2(SW) + $clog2(N_FRM);

  logic          wr, ram_wr, reg_wr, byp_wr;
  logic [12:0]   ram_spr;
  logic          at0, at0_q, at0_d, frame_tick;
  logic          byp_q, byp_d;
  logic [CD-1:0] si_q, si_d, so_q, so_d, sel_pix;
  logic          sel_hit;
  logic [N_SPR-1:0]         hit;
  logic [N_SPR-1:0][CD-1:0] pix;

  // bus decode and frame tick edge detect
  always_comb begin
    wr      = cs & write;
    ram_wr  = wr & ~addr[13];
    reg_wr  = wr & addr[13] & ~addr[12];
    byp_wr  = wr & addr[13] & addr[12];
    ram_spr = addr[12:0] >> AW;
    at0        = (x == 11'd0) && (y == 11'd0);
    at0_d      = at0;
    frame_tick = at0 & ~at0_q;
  end

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    sprite_chan #(
      .CD(CD), .SW(SW), .N_FRM(N_FRM), .AW(AW)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .x          (x),
      .y          (y),
      .frame_tick (frame_tick),
      .ram_we     (ram_wr && ram_spr == 13'(i)),
      .ram_waddr  (addr[AW-1:0]),
      .ram_wdata  (wr_data[CD-1:0]),
      .reg_we     (reg_wr && addr[5:3] == 3'(i)),
      .reg_off    (addr[2:0]),
      .reg_wdata  (wr_data[10:0]),
      .hit_q      (hit[i]),
      .pix_q      (pix[i])
    );
  end

  // lowest opaque hit wins; otherwise pass the delayed input
  always_comb begin
    sel_hit = 1'b0;
    sel_pix = '0;
    for (int i = N_SPR-1; i >= 0; i--) begin
      if (hit[i] && pix[i] != KEY_COLOR) begin
        sel_hit = 1'b1;
        sel_pix = pix[i];
      end
    end
    byp_d = byp_wr ? wr_data[0] : byp_q;
    si_d  = si_rgb;
    so_d  = (byp_q || !sel_hit) ? si_q : sel_pix;
  end

  // pipeline and control flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      at0_q <= 1'b0;
      byp_q <= 1'b0;
      si_q  <= '0;
      so_q  <= '0;
    end else begin
      at0_q <= at0_d;
      byp_q <= byp_d;
      si_q  <= si_d;
      so_q  <= so_d;
    end
  end

  assign so_rgb = so_q;

  logic unused_ok;
  assign unused_ok = ^{wr_data, addr[11:6]};

endmodule

// File: tb/tb_vga_sprite_multi_core.sv
// Directed self-checking bench for vga_sprite_multi_core.
// Bus writes, pixel probes and immediate-assertion checks.
module tb_vga_sprite_multi_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] x = 11'd1000;
  logic [10:0] y = 11'd1000;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] si_rgb = '0;
  logic [11:0] so_rgb;

  int tests = 0;
  int fails = 0;

  vga_sprite_multi_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ram_a(
    input int s, input int f, input int r, input int c);
    logic [13:0] a;
    a = {1'b0, 2'(s), 1'(f), 5'(r), 5'(c)};
    return a;
  endfunction

  function automatic logic [13:0] reg_a(input int s, input int o);
    logic [13:0] a;
    a = {2'b10, 6'd0, 3'(s), 3'(o)};
    return a;
  endfunction

  task automatic check(input string tag,
                       input logic [11:0] obs,
                       input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic probe(input int px, input int py,
                       input logic [11:0] si);
    @(negedge clk);
    x = 11'(px); y = 11'(py); si_rgb = si;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(negedge clk);
    x = 11'd0; y = 11'd0;
    repeat (4) @(negedge clk);
    x = 11'd1000; y = 11'd1000;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_so", so_rgb, 12'h000);
    @(negedge clk) reset_n = 1'b1;

    bus_wr(ram_a(0, 0, 0, 0), 32'hF00);
    bus_wr(reg_a(0, 1), 32'd100);
    bus_wr(reg_a(0, 2), 32'd50);
    bus_wr(reg_a(0, 0), 32'h1);

    probe(99, 50, 12'hABC);
    check("x99_pass", so_rgb, 12'hABC);
    @(negedge clk);
    x = 11'd100; si_rgb = 12'h123;
    @(posedge clk); #1;
    check("lat_1clk", so_rgb, 12'hABC);
    @(posedge clk); #1;
    check("lat_2clk", so_rgb, 12'hF00);

    bus_wr(ram_a(0, 0, 0, 1), 32'h0F0);
    bus_wr(ram_a(1, 0, 0, 1), 32'h00F);
    bus_wr(ram_a(0, 0, 0, 2), 32'h000);
    bus_wr(ram_a(1, 0, 0, 2), 32'h555);
    bus_wr(reg_a(1, 1), 32'd100);
    bus_wr(reg_a(1, 2), 32'd50);
    bus_wr(reg_a(1, 0), 32'h1);
    probe(101, 50, 12'h111);
    check("prio_spr0", so_rgb, 12'h0F0);
    probe(102, 50, 12'h111);
    check("key_spr1", so_rgb, 12'h555);

    bus_wr(reg_a(5, 1), 32'd0);
    bus_wr(reg_a(0, 7), 32'h0);
    probe(100, 50, 12'h111);
    check("unmapped_ign", so_rgb, 12'hF00);

    bus_wr(reg_a(0, 0), 32'h0);
    bus_wr(reg_a(1, 0), 32'h0);
    bus_wr(ram_a(2, 0, 0, 31), 32'h0F0);
    bus_wr(ram_a(2, 0, 0, 0), 32'hAAA);
    bus_wr(reg_a(2, 1), 32'd0);
    bus_wr(reg_a(2, 2), 32'd10);
    bus_wr(reg_a(2, 0), 32'h3);
    probe(0, 10, 12'h222);
    check("hflip_x0", so_rgb, 12'h0F0);
    probe(31, 10, 12'h222);
    check("hflip_x31", so_rgb, 12'hAAA);

    bus_wr(ram_a(3, 0, 0, 0), 32'h111);
    bus_wr(ram_a(3, 1, 0, 0), 32'h222);
    bus_wr(reg_a(3, 1), 32'd500);
    bus_wr(reg_a(3, 2), 32'd500);
    bus_wr(reg_a(3, 4), 32'd2);
    bus_wr(reg_a(3, 0), 32'h5);
    probe(500, 500, 12'h333);
    check("anim_t0", so_rgb, 12'h111);
    tick();
    probe(500, 500, 12'h333);
    check("anim_t1", so_rgb, 12'h111);
    tick();
    probe(500, 500, 12'h333);
    check("anim_t2", so_rgb, 12'h111);
    tick();
    probe(500, 500, 12'h333);
    check("anim_t3", so_rgb, 12'h222);
    tick(); tick();
    probe(500, 500, 12'h333);
    check("anim_t5", so_rgb, 12'h222);
    tick();
    probe(500, 500, 12'h333);
    check("anim_t6", so_rgb, 12'h111);

    bus_wr(ram_a(0, 0, 0, 7), 32'h777);
    bus_wr(reg_a(0, 1), 32'd2040);
    bus_wr(reg_a(0, 0), 32'h1);
    probe(2040, 50, 12'h444);
    check("edge_2040", so_rgb, 12'hF00);
    probe(2047, 50, 12'h444);
    check("edge_2047", so_rgb, 12'h777);
    probe(0, 50, 12'h321);
    check("nowrap_x0", so_rgb, 12'h321);
    probe(23, 50, 12'h654);
    check("nowrap_x23", so_rgb, 12'h654);

    bus_wr(14'h3000, 32'h1);
    probe(2040, 50, 12'h9A5);
    check("bypass", so_rgb, 12'h9A5);
    bus_wr(14'h3000, 32'h0);
    probe(2040, 50, 12'h9A5);
    check("bypass_off", so_rgb, 12'hF00);

    #2 reset_n = 1'b0;
    #1 check("rst_so", so_rgb, 12'h000);
    check("rst_en", 12'(dut.g_spr[0].u_chan.regs_q.en), 12'h0);
    check("rst_x0", 12'(dut.g_spr[0].u_chan.regs_q.x0), 12'h0);
    @(negedge clk) reset_n = 1'b1;
    probe(2040, 50, 12'h0BC);
    check("post_rst_off", so_rgb, 12'h0BC);
    bus_wr(reg_a(0, 1), 32'd2040);
    bus_wr(reg_a(0, 2), 32'd50);
    bus_wr(reg_a(0, 0), 32'h1);
    probe(2040, 50, 12'h0BC);
    check("ram_kept0", so_rgb, 12'hF00);
    probe(2047, 50, 12'h0BC);
    check("ram_kept7", so_rgb, 12'h777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
